dvfs_transition_sequencer: RTL and testbench
============================================

DVFS_TRANSITION_SEQUENCER -- requirements
Module: dvfs_transition_sequencer

Interface
REQ-001 Parameter VOLT_SETTLE_CYCLES, default 64; cycles waited after regulator ack before the next step.
REQ-002 Parameter ACK_TIMEOUT, default 1024; maximum cycles waited for vreg_ack_i or pll_lock_i.
REQ-003 Parameter RESET_VOLT, default 3'd4; RESET_FREQ, default 4'd8; operating point applied at reset.
REQ-004 clk_i  input  1  single clock; all logic is rising-edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 voltage_level_i  input  3  requested voltage level; sampled only on dvfs_update_i.
REQ-007 frequency_level_i  input  4  requested frequency level; sampled only on dvfs_update_i.
REQ-008 dvfs_update_i  input  1  one-cycle request strobe from the PMU.
REQ-009 vreg_level_o  output  3  voltage level driven to the regulator.
REQ-010 vreg_req_o  output  1  regulator change request.
REQ-011 vreg_ack_i  input  1  regulator acknowledge.
REQ-012 pll_freq_o  output  4  frequency level driven to the PLL.
REQ-013 pll_req_o  output  1  one-cycle PLL relock strobe.
REQ-014 pll_lock_i  input  1  PLL locked, level.
REQ-015 clk_hold_o  output  1  gate downstream core clocks during relock.
REQ-016 busy_o  output  1  transition in progress.
REQ-017 done_o  output  1  one-cycle pulse on transition completion, success or error.
REQ-018 error_o  output  1  sticky timeout flag.
REQ-019 transition_count_o  output  16  count of completed transitions.

Function
REQ-020 States: IDLE, V_REQ, V_SETTLE, F_REQ, F_LOCK, FINISH, ERROR.
REQ-021 In IDLE, dvfs_update_i latches the target; busy_o rises the next cycle.
REQ-022 Raising frequency (target_f > cur_f): the voltage step SHALL run first, then the frequency step.
REQ-023 Lowering or equal frequency: the frequency step SHALL run first, then the voltage step.
REQ-024 A step is skipped when its target equals the current value; if both are equal, the FSM goes directly to FINISH, with no handshakes and no count increment.
REQ-025 V_REQ: vreg_level_o = target; vreg_req_o held high and vreg_level_o stable until vreg_ack_i is sampled high; vreg_req_o low the following cycle.
REQ-026 V_SETTLE: wait exactly VOLT_SETTLE_CYCLES cycles after the ack cycle, then update cur_v.
REQ-027 F_REQ: clk_hold_o rises, and pll_freq_o = target with pll_req_o high for one cycle, both in the same cycle.
REQ-028 F_LOCK: wait for pll_lock_i high with pll_req_o low; lock must not be sampled in the pll_req_o cycle; clk_hold_o falls the cycle after lock; then cur_f updates.
REQ-029 FINISH: done_o pulses, busy_o falls, transition_count_o increments (saturates at 16'hFFFF), error_o clears.
REQ-030 A timeout counter resets on entry to V_REQ and F_LOCK; reaching ACK_TIMEOUT enters ERROR.
REQ-031 ERROR: vreg_req_o low, clk_hold_o low, pll_freq_o and vreg_level_o revert to cur_f and cur_v, error_o set, done_o pulses, return to IDLE; no count increment.
REQ-032 dvfs_update_i while busy: stored in a one-deep pending register, latest overwrite wins; the pending request is started the cycle after FINISH or ERROR.
REQ-033 dvfs_update_i in the same cycle as FINISH SHALL be captured as pending, not lost.

Reset
REQ-034 On rst_ni low: state IDLE; vreg_level_o = RESET_VOLT and pll_freq_o = RESET_FREQ; cur_v and cur_f equal these values; vreg_req_o, pll_req_o, clk_hold_o, busy_o, done_o and error_o are 0; transition_count_o is 0; pending is cleared.
REQ-035 Reset mid-transition SHALL abandon the transition immediately, with no done_o pulse.

Configuration
REQ-036 Macro DVFS_SEQ_STATS_EN: when defined, transition_count_o operates per REQ-029; when undefined, transition_count_o is constant 0 and no counter flops are built.

Verification
REQ-037 Raise: cur V4/F8, update V6/F12 -> vreg_req_o with level 6; ack at T; 64 cycles later pll_req_o with freq 12; lock -> done_o, count = 1.
REQ-038 Lower: update V2/F3 from V4/F8 -> pll_req_o with freq 3 before vreg_req_o; vreg_req_o only after lock; clk_hold_o high only from pll_req_o through the lock cycle.
REQ-039 No-op: update V4/F8 at reset point -> done_o 2 cycles later, no req strobes, count stays 0.
REQ-040 Timeout: pll_lock_i held low -> ERROR after 1024 cycles, error_o = 1, pll_freq_o back to 8, clk_hold_o = 0; a later successful update clears error_o.
REQ-041 Pending: two updates (V5/F9, then V6/F10) during busy -> after the first finish, only V6/F10 executes; count = 2.
REQ-042 Reset asserted in V_SETTLE -> outputs at RESET_VOLT/RESET_FREQ, busy_o = 0, no done_o pulse.

Source files
------------

// File: rtl/dvfs_transition_sequencer.sv
// DVFS transition sequencer: orders regulator and PLL steps so voltage always leads frequency up and trails it down.
// Optional macro DVFS_SEQ_STATS_EN builds the completed-transition counter; otherwise transition_count_o is tied to 0.
module dvfs_transition_sequencer #(
    parameter int unsigned VOLT_SETTLE_CYCLES = 64,
    parameter int unsigned ACK_TIMEOUT        = 1024,
    parameter logic [2:0]  RESET_VOLT         = 3'd4,
    parameter logic [3:0]  RESET_FREQ         = 4'd8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  voltage_level_i,
    input  logic [3:0]  frequency_level_i,
    input  logic        dvfs_update_i,
    output logic [2:0]  vreg_level_o,
    output logic        vreg_req_o,
    input  logic        vreg_ack_i,
    output logic [3:0]  pll_freq_o,
    output logic        pll_req_o,
    input  logic        pll_lock_i,
    output logic        clk_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] transition_count_o
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned SW = (VOLT_SETTLE_CYCLES > 1) ? $clog2(VOLT_SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = (VOLT_SETTLE_CYCLES > 0) ? SW'(VOLT_SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_V_REQ, S_V_SETTLE, S_F_REQ, S_F_LOCK, S_FINISH, S_ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      tgt_v_q, tgt_v_d, cur_v_q, cur_v_d;
    logic [3:0]      tgt_f_q, tgt_f_d, cur_f_q, cur_f_d;
    logic            raise_q, raise_d;
    logic            pend_vld_q, pend_vld_d;
    logic [2:0]      pend_v_q, pend_v_d;
    logic [3:0]      pend_f_q, pend_f_d;
    logic [2:0]      vreg_level_q, vreg_level_d;
    logic            vreg_req_q, vreg_req_d;
    logic [3:0]      pll_freq_q, pll_freq_d;
    logic            pll_req_q, pll_req_d;
    logic            clk_hold_q, clk_hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [SW-1:0]   settle_q, settle_d;

    logic            start;
    logic [2:0]      req_v;
    logic [3:0]      req_f;

    // A fresh strobe in the IDLE cycle overrides any pending request.
    assign start = (state_q == S_IDLE) && (dvfs_update_i || pend_vld_q);
    assign req_v = dvfs_update_i ? voltage_level_i   : pend_v_q;
    assign req_f = dvfs_update_i ? frequency_level_i : pend_f_q;

    always_comb begin
        state_d      = state_q;
        tgt_v_d      = tgt_v_q;
        tgt_f_d      = tgt_f_q;
        cur_v_d      = cur_v_q;
        cur_f_d      = cur_f_q;
        raise_d      = raise_q;
        pend_vld_d   = pend_vld_q;
        pend_v_d     = pend_v_q;
        pend_f_d     = pend_f_q;
        vreg_level_d = vreg_level_q;
        vreg_req_d   = vreg_req_q;
        pll_freq_d   = pll_freq_q;
        pll_req_d    = 1'b0;
        clk_hold_d   = clk_hold_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        tmo_d        = tmo_q;
        settle_d     = settle_q;

        if (state_q != S_IDLE && dvfs_update_i) begin
            pend_vld_d = 1'b1;
            pend_v_d   = voltage_level_i;
            pend_f_d   = frequency_level_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_vld_d = 1'b0;
                    tgt_v_d    = req_v;
                    tgt_f_d    = req_f;
                    raise_d    = (req_f > cur_f_q);
                    busy_d     = 1'b1;
                    if (req_v == cur_v_q && req_f == cur_f_q)
                        state_d = S_FINISH;
                    else if ((req_f > cur_f_q && req_v != cur_v_q) || req_f == cur_f_q)
                        state_d = S_V_REQ;
                    else
                        state_d = S_F_REQ;
                end
            end
            S_V_REQ: begin
                if (vreg_ack_i) begin
                    vreg_req_d = 1'b0;
                    state_d    = S_V_SETTLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_V_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    cur_v_d = tgt_v_q;
                    state_d = (raise_q && tgt_f_q != cur_f_q) ? S_F_REQ : S_FINISH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_F_REQ: begin
                state_d = S_F_LOCK;
            end
            S_F_LOCK: begin
                if (pll_lock_i) begin
                    clk_hold_d = 1'b0;
                    cur_f_d    = tgt_f_q;
                    state_d    = (!raise_q && tgt_v_q != cur_v_q) ? S_V_REQ : S_FINISH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                error_d = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Entry actions keyed on the next state so every output stays registered.
        if (state_d == S_V_REQ && state_q != S_V_REQ) begin
            vreg_level_d = tgt_v_d;
            vreg_req_d   = 1'b1;
            tmo_d        = '0;
        end
        if (state_d == S_V_SETTLE && state_q == S_V_REQ)
            settle_d = '0;
        if (state_d == S_F_REQ) begin
            pll_freq_d = tgt_f_d;
            pll_req_d  = 1'b1;
            clk_hold_d = 1'b1;
        end
        if (state_d == S_F_LOCK && state_q == S_F_REQ)
            tmo_d = '0;
        if (state_d == S_ERROR && state_q != S_ERROR) begin
            vreg_req_d   = 1'b0;
            clk_hold_d   = 1'b0;
            pll_freq_d   = cur_f_q;
            vreg_level_d = cur_v_q;
            error_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            tgt_v_q      <= RESET_VOLT;
            tgt_f_q      <= RESET_FREQ;
            cur_v_q      <= RESET_VOLT;
            cur_f_q      <= RESET_FREQ;
            raise_q      <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_v_q     <= '0;
            pend_f_q     <= '0;
            vreg_level_q <= RESET_VOLT;
            vreg_req_q   <= 1'b0;
            pll_freq_q   <= RESET_FREQ;
            pll_req_q    <= 1'b0;
            clk_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tmo_q        <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            tgt_v_q      <= tgt_v_d;
            tgt_f_q      <= tgt_f_d;
            cur_v_q      <= cur_v_d;
            cur_f_q      <= cur_f_d;
            raise_q      <= raise_d;
            pend_vld_q   <= pend_vld_d;
            pend_v_q     <= pend_v_d;
            pend_f_q     <= pend_f_d;
            vreg_level_q <= vreg_level_d;
            vreg_req_q   <= vreg_req_d;
            pll_freq_q   <= pll_freq_d;
            pll_req_q    <= pll_req_d;
            clk_hold_q   <= clk_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
        end
    end

`ifdef DVFS_SEQ_STATS_EN
    logic [15:0] count_q, count_d;
    logic        noop_q, noop_d;

    // No-op requests pass through FINISH but are not counted.
    always_comb begin
        noop_d  = noop_q;
        count_d = count_q;
        if (start)
            noop_d = (req_v == cur_v_q) && (req_f == cur_f_q);
        if (state_q == S_FINISH && !noop_q && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            noop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            noop_q  <= noop_d;
        end
    end

    assign transition_count_o = count_q;
`else
    assign transition_count_o = '0;
`endif

    assign vreg_level_o = vreg_level_q;
    assign vreg_req_o   = vreg_req_q;
    assign pll_freq_o   = pll_freq_q;
    assign pll_req_o    = pll_req_q;
    assign clk_hold_o   = clk_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed bench for dvfs_transition_sequencer: raise/lower ordering, no-op, timeout, pending and reset cases.
// Expected counter values follow DVFS_SEQ_STATS_EN (0 when the macro is undefined).
module tb_dvfs_transition_sequencer;

    logic        clk, rst_n;
    logic [2:0]  vol;
    logic [3:0]  freq;
    logic        upd, ack, lock;
    logic [2:0]  vreg_level;
    logic        vreg_req;
    logic [3:0]  pll_freq;
    logic        pll_req, clk_hold, busy, done, err;
    logic [15:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int k;

`ifdef DVFS_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dvfs_transition_sequencer dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .voltage_level_i    (vol),
        .frequency_level_i  (freq),
        .dvfs_update_i      (upd),
        .vreg_level_o       (vreg_level),
        .vreg_req_o         (vreg_req),
        .vreg_ack_i         (ack),
        .pll_freq_o         (pll_freq),
        .pll_req_o          (pll_req),
        .pll_lock_i         (lock),
        .clk_hold_o         (clk_hold),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (err),
        .transition_count_o (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 = done_o, 1 = pll_req_o, 2 = error_o; k = edges waited (== lim on expiry)
    task automatic wait_for(input int sel, input int lim, output int kk);
        kk = 0;
        while (kk < lim && !((sel == 0 && done === 1'b1) || (sel == 1 && pll_req === 1'b1) ||
                             (sel == 2 && err === 1'b1))) begin
            tick();
            kk++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        upd = 1'b0; ack = 1'b0; lock = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic request(input logic [2:0] v, input logic [3:0] f);
        vol = v; freq = f; upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        upd = 1'b0; ack = 1'b0; lock = 1'b0; vol = '0; freq = '0;
        tick(); tick();
        n_cmp++; if ({vreg_level, pll_freq} !== {3'd4, 4'd8}) begin n_bad++;
            $display("FAIL reset_levels: got V%0d/F%0d want V4/F8", vreg_level, pll_freq); end
        n_cmp++; if ({vreg_req, pll_req, clk_hold, busy, done, err} !== 6'b0) begin n_bad++;
            $display("FAIL reset_flags: got %b want 000000", {vreg_req, pll_req, clk_hold, busy, done, err}); end
        n_cmp++; if (count !== 16'd0) begin n_bad++;
            $display("FAIL reset_count: got %0d want 0", count); end
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if ({busy, done, vreg_req, pll_req} !== 4'b0) begin n_bad++;
            $display("FAIL reset_idle: got %b want 0000", {busy, done, vreg_req, pll_req}); end
    endtask

    task automatic test_raise();
        request(3'd6, 4'd12);
        n_cmp++; if ({busy, vreg_req, vreg_level, pll_req} !== {1'b1, 1'b1, 3'd6, 1'b0}) begin n_bad++;
            $display("FAIL raise_vreq: got busy=%b req=%b lvl=%0d pll_req=%b want 1 1 6 0", busy, vreg_req, vreg_level, pll_req); end
        tick(); tick(); tick();
        n_cmp++; if ({vreg_req, vreg_level} !== {1'b1, 3'd6}) begin n_bad++;
            $display("FAIL raise_vreq_hold: got req=%b lvl=%0d want 1 6", vreg_req, vreg_level); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++; if (vreg_req !== 1'b0) begin n_bad++;
            $display("FAIL raise_vreq_drop: got %b want 0", vreg_req); end
        wait_for(1, 200, k);
        n_cmp++; if (k !== 64) begin n_bad++;
            $display("FAIL raise_settle_len: got %0d want 64", k); end
        n_cmp++; if ({pll_freq, clk_hold} !== {4'd12, 1'b1}) begin n_bad++;
            $display("FAIL raise_pll: got F%0d hold=%b want F12 1", pll_freq, clk_hold); end
        tick();
        n_cmp++; if ({pll_req, clk_hold} !== 2'b01) begin n_bad++;
            $display("FAIL raise_pll_strobe: got req=%b hold=%b want 0 1", pll_req, clk_hold); end
        tick(); tick();
        lock = 1'b1; tick(); lock = 1'b0;
        n_cmp++; if ({clk_hold, busy, done} !== 3'b010) begin n_bad++;
            $display("FAIL raise_lock: got hold=%b busy=%b done=%b want 0 1 0", clk_hold, busy, done); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++;
            $display("FAIL raise_done: got done=%b busy=%b want 1 0", done, busy); end
        n_cmp++; if (count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++;
            $display("FAIL raise_count: got %0d want %0d", count, STATS ? 1 : 0); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL raise_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_lower();
        do_reset();
        request(3'd2, 4'd3);
        n_cmp++; if ({pll_req, pll_freq, clk_hold, vreg_req} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin n_bad++;
            $display("FAIL lower_pll_first: got req=%b F%0d hold=%b vreq=%b want 1 3 1 0", pll_req, pll_freq, clk_hold, vreg_req); end
        tick(); tick(); tick();
        n_cmp++; if ({vreg_req, clk_hold, pll_req} !== 3'b010) begin n_bad++;
            $display("FAIL lower_wait_lock: got vreq=%b hold=%b preq=%b want 0 1 0", vreg_req, clk_hold, pll_req); end
        lock = 1'b1; tick(); lock = 1'b0;
        n_cmp++; if ({vreg_req, vreg_level, clk_hold} !== {1'b1, 3'd2, 1'b0}) begin n_bad++;
            $display("FAIL lower_vreq_after_lock: got req=%b lvl=%0d hold=%b want 1 2 0", vreg_req, vreg_level, clk_hold); end
        ack = 1'b1; tick(); ack = 1'b0;
        wait_for(0, 200, k);
        n_cmp++; if (k !== 65) begin n_bad++;
            $display("FAIL lower_done_latency: got %0d want 65", k); end
        n_cmp++; if ({vreg_level, pll_freq, busy} !== {3'd2, 4'd3, 1'b0}) begin n_bad++;
            $display("FAIL lower_final: got V%0d/F%0d busy=%b want V2/F3 0", vreg_level, pll_freq, busy); end
        n_cmp++; if (count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++;
            $display("FAIL lower_count: got %0d want %0d", count, STATS ? 1 : 0); end
    endtask

    task automatic test_noop();
        do_reset();
        request(3'd4, 4'd8);
        n_cmp++; if ({busy, done, vreg_req, pll_req} !== 4'b1000) begin n_bad++;
            $display("FAIL noop_busy: got %b want 1000", {busy, done, vreg_req, pll_req}); end
        tick();
        n_cmp++; if ({done, busy, vreg_req, pll_req, clk_hold} !== 5'b10000) begin n_bad++;
            $display("FAIL noop_done: got %b want 10000", {done, busy, vreg_req, pll_req, clk_hold}); end
        n_cmp++; if (count !== 16'd0) begin n_bad++;
            $display("FAIL noop_count: got %0d want 0", count); end
    endtask

    task automatic test_timeout();
        request(3'd4, 4'd12);
        n_cmp++; if ({pll_req, pll_freq} !== {1'b1, 4'd12}) begin n_bad++;
            $display("FAIL tmo_pll_req: got req=%b F%0d want 1 F12", pll_req, pll_freq); end
        tick();
        wait_for(2, 1100, k);
        n_cmp++; if (k !== 1024) begin n_bad++;
            $display("FAIL tmo_latency: got %0d want 1024", k); end
        n_cmp++; if ({pll_freq, vreg_level, clk_hold, vreg_req} !== {4'd8, 3'd4, 1'b0, 1'b0}) begin n_bad++;
            $display("FAIL tmo_revert: got F%0d V%0d hold=%b vreq=%b want F8 V4 0 0", pll_freq, vreg_level, clk_hold, vreg_req); end
        tick();
        n_cmp++; if ({done, busy, err} !== 3'b101) begin n_bad++;
            $display("FAIL tmo_done: got done=%b busy=%b err=%b want 1 0 1", done, busy, err); end
        tick();
        request(3'd5, 4'd8);
        n_cmp++; if ({vreg_req, vreg_level, err} !== {1'b1, 3'd5, 1'b1}) begin n_bad++;
            $display("FAIL tmo_retry_vreq: got req=%b lvl=%0d err=%b want 1 5 1", vreg_req, vreg_level, err); end
        ack = 1'b1; tick(); ack = 1'b0;
        wait_for(0, 200, k);
        n_cmp++; if ({done, err} !== 2'b10) begin n_bad++;
            $display("FAIL tmo_err_clear: got done=%b err=%b want 1 0", done, err); end
        n_cmp++; if (count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++;
            $display("FAIL tmo_count: got %0d want %0d", count, STATS ? 1 : 0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        request(3'd7, 4'd8);
        request(3'd5, 4'd9);
        request(3'd6, 4'd10);
        n_cmp++; if ({vreg_req, vreg_level} !== {1'b1, 3'd7}) begin n_bad++;
            $display("FAIL b2b_first_vreq: got req=%b lvl=%0d want 1 7", vreg_req, vreg_level); end
        ack = 1'b1; tick(); ack = 1'b0;
        wait_for(0, 200, k);
        n_cmp++; if ({done, busy, vreg_level} !== {1'b1, 1'b0, 3'd7}) begin n_bad++;
            $display("FAIL b2b_first_done: got done=%b busy=%b V%0d want 1 0 7", done, busy, vreg_level); end
        tick();
        n_cmp++; if ({busy, vreg_req, vreg_level} !== {1'b1, 1'b1, 3'd6}) begin n_bad++;
            $display("FAIL b2b_pending_start: got busy=%b req=%b lvl=%0d want 1 1 6", busy, vreg_req, vreg_level); end
        ack = 1'b1; tick(); ack = 1'b0;
        wait_for(1, 200, k);
        n_cmp++; if ({pll_req, pll_freq} !== {1'b1, 4'd10}) begin n_bad++;
            $display("FAIL b2b_pending_pll: got req=%b F%0d want 1 F10", pll_req, pll_freq); end
        lock = 1'b1; tick(); tick(); lock = 1'b0;
        wait_for(0, 20, k);
        n_cmp++; if (k !== 1) begin n_bad++;
            $display("FAIL b2b_second_done: got %0d want 1", k); end
        n_cmp++; if (count !== (STATS ? 16'd2 : 16'd0)) begin n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", count, STATS ? 2 : 0); end
        tick(); tick(); tick();
        n_cmp++; if ({busy, vreg_req, pll_req} !== 3'b000) begin n_bad++;
            $display("FAIL b2b_no_extra: got %b want 000", {busy, vreg_req, pll_req}); end
    endtask

    task automatic test_finish_capture();
        request(3'd6, 4'd9);
        n_cmp++; if ({pll_req, pll_freq, vreg_req} !== {1'b1, 4'd9, 1'b0}) begin n_bad++;
            $display("FAIL fcap_pll: got req=%b F%0d vreq=%b want 1 F9 0", pll_req, pll_freq, vreg_req); end
        tick();
        lock = 1'b1; tick(); lock = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++;
            $display("FAIL fcap_in_finish: got busy=%b done=%b want 1 0", busy, done); end
        request(3'd5, 4'd9);
        n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++;
            $display("FAIL fcap_done: got done=%b busy=%b want 1 0", done, busy); end
        tick();
        n_cmp++; if ({busy, vreg_req, vreg_level} !== {1'b1, 1'b1, 3'd5}) begin n_bad++;
            $display("FAIL fcap_started: got busy=%b req=%b lvl=%0d want 1 1 5", busy, vreg_req, vreg_level); end
        ack = 1'b1; tick(); ack = 1'b0;
        wait_for(0, 200, k);
        n_cmp++; if (count !== (STATS ? 16'd4 : 16'd0)) begin n_bad++;
            $display("FAIL fcap_count: got %0d want %0d", count, STATS ? 4 : 0); end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        tick();
        request(3'd7, 4'd12);
        ack = 1'b1; tick(); ack = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({vreg_level, pll_freq, busy, done, vreg_req, clk_hold} !== {3'd4, 4'd8, 4'b0}) begin n_bad++;
            $display("FAIL rstmid_outputs: got V%0d F%0d busy=%b done=%b req=%b hold=%b want V4 F8 0 0 0 0",
                     vreg_level, pll_freq, busy, done, vreg_req, clk_hold); end
        n_cmp++; if (count !== 16'd0) begin n_bad++;
            $display("FAIL rstmid_count: got %0d want 0", count); end
        tick(); tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done === 1'b1 || pll_req === 1'b1) seen_done = 1'b1;
        end
        n_cmp++; if ({seen_done, busy} !== 2'b00) begin n_bad++;
            $display("FAIL rstmid_abandon: got done_seen=%b busy=%b want 0 0", seen_done, busy); end
    endtask

    initial begin
        rst_n = 1'b0; upd = 1'b0; ack = 1'b0; lock = 1'b0; vol = '0; freq = '0;
        test_reset();
        test_raise();
        test_lower();
        test_noop();
        test_timeout();
        test_back_to_back();
        test_finish_capture();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
